mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports: clock  in  1  single system clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have per requester X in {data, fetch, io}: reqX in 1 access request; weX in 1 write (1) / read (0); addrX in 16 word address; wdataX in 16 write data.
REQ-003 SHALL have per requester X: gntX out 1 access issued this cycle; rvalidX out 1 read data valid this cycle.
REQ-004 SHALL have rdata  out  16  shared read data, valid only when some rvalidX is high.
REQ-005 SHALL have memory-side ports: memEnabled out 1; memWriteEnabled out 1; memAddr out 16; memDataOut out 16; memDataIn in 16 (synchronous memory, data one cycle after enable).
REQ-006 SHALL have parameter IO_STARVE_LIMIT, default 7: io wait cycles before io is promoted to top priority.

Function
REQ-007 SHALL arbitrate combinationally in cycle N among eligible requests and register the winner's outputs, so gntX, memEnabled, memWriteEnabled, memAddr and memDataOut are asserted in cycle N+1.
REQ-008 SHALL mask a requester's req in any cycle its gnt is high; a single requester is therefore granted at most every second cycle, while different requesters may be granted in consecutive cycles.
REQ-009 SHALL use fixed priority data > fetch > io unless promotion (REQ-011) is active.
REQ-010 SHALL maintain a 3-bit ioWait counter: increment, saturating at IO_STARVE_LIMIT, in each cycle reqio is high and io does not win arbitration; clear when io wins or reqio is low.
REQ-011 SHALL give io top priority, above data, while ioWait == IO_STARVE_LIMIT and reqio is high.
REQ-012 SHALL issue at most one memory access per cycle; memEnabled SHALL be low in any cycle with no gnt.
REQ-013 SHALL on a granted read (we=0) assert rvalidX for exactly one cycle, the cycle after gntX, with rdata = memDataIn in that cycle.
REQ-014 SHALL on a granted write (we=1) assert memWriteEnabled with memDataOut = wdataX and never assert rvalidX.
REQ-015 SHALL tolerate withdrawal: a req dropped before its gnt SHALL produce no grant and no memory access.
REQ-016 SHALL drive memAddr and memDataOut to 0 when no access is issued.
REQ-017 SHALL ensure at most one gntX and at most one rvalidX are high in any cycle.

Reset
REQ-018 SHALL on reset assertion immediately force low all gntX, rvalidX, memEnabled and memWriteEnabled; force 0 on memAddr, memDataOut and ioWait; discard any pending read response.
REQ-019 SHALL issue the first grant no earlier than the first rising edge after reset deassertion.

Structure
REQ-020 SHALL place requester index constants (DATA=0, FETCH=1, IO=2), the IO_STARVE_LIMIT default and address/data width constants in the shared processor package.
REQ-021 SHALL implement the priority/promotion selection as one sub-module, mem_arb_priority (combinational: masked reqs, promote -> one-hot winner); all state stays in the top module.

Verification
REQ-022 SHALL cover: reqdata=reqfetch=1 in cycle 0 (data read addr 0x0010, fetch addr 0x0020) -> gntdata cycle 1, memAddr=0x0010; gntfetch cycle 2, memAddr=0x0020; rvaliddata cycle 2; rvalidfetch cycle 3.
REQ-023 SHALL cover: reqdata held continuously with wedata=1, addr 0x0100, wdata 0xBEEF -> gntdata in alternate cycles only, memWriteEnabled=1, memDataOut=0xBEEF, no rvaliddata.
REQ-024 SHALL cover: reqdata and reqfetch each re-requesting immediately after every grant, reqio held -> io granted in the cycle after ioWait reaches 7 (at most 8 cycles after reqio rises), then ioWait=0.
REQ-025 SHALL cover: reqfetch raised cycle 0 and dropped cycle 1 while data wins cycle 0 -> no gntfetch, no memory access at fetch address.
REQ-026 SHALL cover: reset asserted in the cycle between gntio (read) and its rvalidio -> rvalidio never asserts, all outputs 0 asynchronously, normal grants resume after reset release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared constants and types for the three-requester memory
//                port arbiter (data, fetch, io).
//  Revision    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Requester indices, in fixed-priority order (lowest index wins)
  localparam int c_DATA    = 0;
  localparam int c_FETCH   = 1;
  localparam int c_IO      = 2;
  localparam int c_NUM_REQ = 3;

  // Bus widths
  localparam int c_ADDR_W  = 16;
  localparam int c_DATA_W  = 16;

  // io starvation guard: default wait limit and counter width
  localparam int c_IO_STARVE_LIMIT = 7;
  localparam int c_WAIT_W          = 3;

  typedef logic [c_NUM_REQ-1:0] reqVec_t;
  typedef logic [c_ADDR_W-1:0]  addr_t;
  typedef logic [c_DATA_W-1:0]  data_t;

  // Everything the memory needs from one requester
  typedef struct packed {
    logic  we;
    addr_t addr;
    data_t wdata;
  } reqInfo_t;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Requester and memory-side signal bundle of the arbiter.
//                master = requesters + memory model, slave = arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  // Requester side
  logic  reqdata,   wedata;
  addr_t addrdata;
  data_t wdatadata;
  logic  reqfetch,  wefetch;
  addr_t addrfetch;
  data_t wdatafetch;
  logic  reqio,     weio;
  addr_t addrio;
  data_t wdataio;

  logic  gntdata,    gntfetch,    gntio;
  logic  rvaliddata, rvalidfetch, rvalidio;
  data_t rdata;

  // Memory side
  logic  memEnabled;
  logic  memWriteEnabled;
  addr_t memAddr;
  data_t memDataOut;
  data_t memDataIn;

  modport master (
    output reqdata, wedata, addrdata, wdatadata,
    output reqfetch, wefetch, addrfetch, wdatafetch,
    output reqio, weio, addrio, wdataio,
    output memDataIn,
    input  gntdata, gntfetch, gntio,
    input  rvaliddata, rvalidfetch, rvalidio, rdata,
    input  memEnabled, memWriteEnabled, memAddr, memDataOut
  );

  modport slave (
    input  reqdata, wedata, addrdata, wdatadata,
    input  reqfetch, wefetch, addrfetch, wdatafetch,
    input  reqio, weio, addrio, wdataio,
    input  memDataIn,
    output gntdata, gntfetch, gntio,
    output rvaliddata, rvalidfetch, rvalidio, rdata,
    output memEnabled, memWriteEnabled, memAddr, memDataOut
  );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_priority.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_priority
//  Description : Combinational winner selection. Fixed priority
//                data > fetch > io, with io lifted above data while the
//                starvation promote flag is set. Output is one-hot or zero.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_priority
  import mem_port_arbiter_pkg::*;
(
  input  wire reqVec_t i_reqMasked,
  input  wire logic    i_promote,
  output reqVec_t      o_winner
);

  // Pick exactly one eligible requester, promoted io first
  always_comb begin
    o_winner = '0;
    if (i_promote && i_reqMasked[c_IO]) begin
      o_winner[c_IO] = 1'b1;
    end else if (i_reqMasked[c_DATA]) begin
      o_winner[c_DATA] = 1'b1;
    end else if (i_reqMasked[c_FETCH]) begin
      o_winner[c_FETCH] = 1'b1;
    end else if (i_reqMasked[c_IO]) begin
      o_winner[c_IO] = 1'b1;
    end
  end

endmodule : mem_arb_priority
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Three-requester arbiter for a single synchronous memory
//                port. Arbitration is combinational in cycle N, the access
//                is presented in N+1 and read data returns in N+2.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int IO_STARVE_LIMIT = c_IO_STARVE_LIMIT  // must fit in c_WAIT_W bits
)(
  input  wire logic         clock,
  input  wire logic         reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(IO_STARVE_LIMIT);

  reqVec_t             w_req;
  reqVec_t             w_reqMasked;
  reqVec_t             w_winner;
  reqInfo_t            w_info [c_NUM_REQ];
  reqInfo_t            w_sel;
  logic                w_promote;
  logic                w_access;

  reqVec_t             r_gnt;
  reqVec_t             r_gntRead;
  reqVec_t             r_rvalid;
  logic [c_WAIT_W-1:0] r_ioWait;
  logic                r_memEnabled;
  logic                r_memWriteEnabled;
  addr_t               r_memAddr;
  data_t               r_memDataOut;

  // Gather requester fields into index-addressable form
  assign w_req[c_DATA]  = bus.reqdata;
  assign w_req[c_FETCH] = bus.reqfetch;
  assign w_req[c_IO]    = bus.reqio;

  assign w_info[c_DATA]  = '{we: bus.wedata,  addr: bus.addrdata,  wdata: bus.wdatadata};
  assign w_info[c_FETCH] = '{we: bus.wefetch, addr: bus.addrfetch, wdata: bus.wdatafetch};
  assign w_info[c_IO]    = '{we: bus.weio,    addr: bus.addrio,    wdata: bus.wdataio};

  // A requester being granted this cycle sits out the next arbitration,
  // so back-to-back grants always go to different requesters.
  assign w_reqMasked = w_req & ~r_gnt;
  assign w_promote   = bus.reqio && (r_ioWait == c_WAIT_MAX);

  mem_arb_priority u_priority (
    .i_reqMasked (w_reqMasked),
    .i_promote   (w_promote),
    .o_winner    (w_winner)
  );

  assign w_access = |w_winner;

  // Mux the winner's fields; all-zero when nobody wins
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < c_NUM_REQ; i++) begin
      if (w_winner[i]) begin
        w_sel = w_info[i];
      end
    end
  end

  // Register the grant and memory command; track reads for the response cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gnt             <= '0;
      r_gntRead         <= '0;
      r_rvalid          <= '0;
      r_memEnabled      <= 1'b0;
      r_memWriteEnabled <= 1'b0;
      r_memAddr         <= '0;
      r_memDataOut      <= '0;
    end else begin
      r_gnt             <= w_winner;
      r_gntRead         <= w_winner & {c_NUM_REQ{~w_sel.we}};
      r_rvalid          <= r_gntRead;
      r_memEnabled      <= w_access;
      r_memWriteEnabled <= w_access & w_sel.we;
      r_memAddr         <= w_sel.addr;
      r_memDataOut      <= w_sel.we ? w_sel.wdata : '0;
    end
  end

  // io starvation counter: counts cycles io asks but loses, saturating
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ioWait <= '0;
    end else if (!bus.reqio || w_winner[c_IO]) begin
      r_ioWait <= '0;
    end else if (r_ioWait != c_WAIT_MAX) begin
      r_ioWait <= r_ioWait + 1'b1;
    end
  end

  // Drive the bundle from the registered state
  assign bus.gntdata         = r_gnt[c_DATA];
  assign bus.gntfetch        = r_gnt[c_FETCH];
  assign bus.gntio           = r_gnt[c_IO];
  assign bus.rvaliddata      = r_rvalid[c_DATA];
  assign bus.rvalidfetch     = r_rvalid[c_FETCH];
  assign bus.rvalidio        = r_rvalid[c_IO];
  assign bus.rdata           = (|r_rvalid) ? bus.memDataIn : '0;
  assign bus.memEnabled      = r_memEnabled;
  assign bus.memWriteEnabled = r_memWriteEnabled;
  assign bus.memAddr         = r_memAddr;
  assign bus.memDataOut      = r_memDataOut;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter: directed scenarios
//                followed by random traffic against a cycle reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LIMIT = 7;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.IO_STARVE_LIMIT(LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference state: what the outputs should show in the current cycle
  logic [2:0]  expGnt;
  logic [2:0]  expRvalid;
  logic        expEn;
  logic        expWe;
  logic [15:0] expAddr;
  logic [15:0] expDout;
  int          modelWait;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    expGnt = '0; expRvalid = '0; expEn = 0; expWe = 0;
    expAddr = '0; expDout = '0; modelWait = 0;
  endtask

  function automatic logic reqOf(int i);
    case (i)
      0: return bus.reqdata;
      1: return bus.reqfetch;
      default: return bus.reqio;
    endcase
  endfunction

  function automatic logic weOf(int i);
    case (i)
      0: return bus.wedata;
      1: return bus.wefetch;
      default: return bus.weio;
    endcase
  endfunction

  function automatic logic [15:0] addrOf(int i);
    case (i)
      0: return bus.addrdata;
      1: return bus.addrfetch;
      default: return bus.addrio;
    endcase
  endfunction

  function automatic logic [15:0] wdataOf(int i);
    case (i)
      0: return bus.wdatadata;
      1: return bus.wdatafetch;
      default: return bus.wdataio;
    endcase
  endfunction

  task automatic setReq(input int i, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
    case (i)
      0: begin bus.reqdata  = r; bus.wedata  = w; bus.addrdata  = a; bus.wdatadata  = d; end
      1: begin bus.reqfetch = r; bus.wefetch = w; bus.addrfetch = a; bus.wdatafetch = d; end
      default: begin bus.reqio = r; bus.weio = w; bus.addrio = a; bus.wdataio = d; end
    endcase
  endtask

  task automatic idleAll();
    for (int i = 0; i < 3; i++) setReq(i, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Advance one cycle: decide the winner from the inputs now applied, then
  // compare every output in the following cycle against the prediction.
  task automatic tick();
    int          win;
    logic [2:0]  nGnt, nRvalid;
    logic        nEn, nWe;
    logic [15:0] nAddr, nDout;
    win = -1;
    if (bus.reqio && !expGnt[2] && modelWait >= LIMIT) win = 2;
    else
      for (int i = 0; i < 3; i++)
        if (win < 0 && reqOf(i) && !expGnt[i]) win = i;
    nRvalid = (expEn && !expWe) ? expGnt : 3'b000;
    if (win >= 0) begin
      nGnt  = 3'b001 << win;
      nEn   = 1'b1;
      nWe   = weOf(win);
      nAddr = addrOf(win);
      nDout = nWe ? wdataOf(win) : 16'h0;
    end else begin
      nGnt = '0; nEn = 0; nWe = 0; nAddr = '0; nDout = '0;
    end
    if (bus.reqio && win != 2) modelWait = (modelWait + 1 > LIMIT) ? LIMIT : modelWait + 1;
    else modelWait = 0;

    @(posedge clock);
    #1;
    bus.memDataIn = 16'($urandom);
    #1;
    expGnt = nGnt; expRvalid = nRvalid; expEn = nEn; expWe = nWe;
    expAddr = nAddr; expDout = nDout;
    chk("gnt",    {13'b0, bus.gntio, bus.gntfetch, bus.gntdata}, {13'b0, expGnt});
    chk("rvalid", {13'b0, bus.rvalidio, bus.rvalidfetch, bus.rvaliddata}, {13'b0, expRvalid});
    chk("memEn",  {15'b0, bus.memEnabled}, {15'b0, expEn});
    chk("memWe",  {15'b0, bus.memWriteEnabled}, {15'b0, expWe});
    chk("memAddr", bus.memAddr, expAddr);
    if (!(expEn && !expWe)) chk("memDataOut", bus.memDataOut, expDout);
    if (|expRvalid) chk("rdata", bus.rdata, bus.memDataIn);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_gnt"},    {13'b0, bus.gntio, bus.gntfetch, bus.gntdata}, 16'h0);
    chk({tag, "_rvalid"}, {13'b0, bus.rvalidio, bus.rvalidfetch, bus.rvaliddata}, 16'h0);
    chk({tag, "_memEn"},  {15'b0, bus.memEnabled}, 16'h0);
    chk({tag, "_memWe"},  {15'b0, bus.memWriteEnabled}, 16'h0);
    chk({tag, "_memAddr"}, bus.memAddr, 16'h0);
    chk({tag, "_memDataOut"}, bus.memDataOut, 16'h0);
    chk({tag, "_ioWait"}, {13'b0, dut.r_ioWait}, 16'h0);
  endtask

  initial begin
    int n;
    int grants;
    int fetchSeen;
    checks = 0;
    errors = 0;
    idleAll();
    bus.memDataIn = 16'h0;
    modelReset();

    // Power-on reset
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 checkAllZero("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;

    // Two reads in the same cycle: data first, fetch next, responses follow
    setReq(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    setReq(1, 1'b1, 1'b0, 16'h0020, 16'h0);
    tick();
    chk("s22_gntdata", {15'b0, bus.gntdata}, 16'h1);
    chk("s22_addr1", bus.memAddr, 16'h0010);
    setReq(0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    chk("s22_gntfetch", {15'b0, bus.gntfetch}, 16'h1);
    chk("s22_addr2", bus.memAddr, 16'h0020);
    chk("s22_rvaliddata", {15'b0, bus.rvaliddata}, 16'h1);
    setReq(1, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    chk("s22_rvalidfetch", {15'b0, bus.rvalidfetch}, 16'h1);
    tick();

    // Continuous data write: granted only on alternate cycles
    setReq(0, 1'b1, 1'b1, 16'h0100, 16'hBEEF);
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.gntdata) begin
        grants++;
        chk("s23_wdata", bus.memDataOut, 16'hBEEF);
      end
    end
    chk("s23_grants", 16'(grants), 16'd4);
    idleAll();
    tick(); tick();

    // Withdrawn fetch request never reaches memory
    setReq(0, 1'b1, 1'b0, 16'h0444, 16'h0);
    setReq(1, 1'b1, 1'b0, 16'h0555, 16'h0);
    fetchSeen = 0;
    tick();
    idleAll();
    for (int k = 0; k < 3; k++) begin
      if (bus.gntfetch || (bus.memEnabled && bus.memAddr == 16'h0555)) fetchSeen++;
      tick();
    end
    chk("s25_nofetch", 16'(fetchSeen), 16'd0);

    // io starvation: data and fetch saturate the port, io promoted after 7
    setReq(0, 1'b1, 1'b0, 16'h0A00, 16'h0);
    setReq(1, 1'b1, 1'b0, 16'h0B00, 16'h0);
    setReq(2, 1'b1, 1'b0, 16'h0777, 16'h0);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (bus.gntio) break;
    end
    chk("s24_cycles", 16'(n), 16'd8);
    chk("s24_ioWait", {13'b0, dut.r_ioWait}, 16'h0);
    idleAll();
    tick(); tick(); tick();

    // Reset between io read grant and its response
    setReq(2, 1'b1, 1'b0, 16'h0300, 16'h0);
    tick();
    chk("s26_gntio", {15'b0, bus.gntio}, 16'h1);
    idleAll();
    #2 reset = 1'b1;
    #1 checkAllZero("s26_async");
    @(posedge clock);
    #1;
    chk("s26_norvalid", {15'b0, bus.rvalidio}, 16'h0);
    reset = 1'b0;
    modelReset();
    #1;
    setReq(0, 1'b1, 1'b1, 16'h0900, 16'h1234);
    tick();
    chk("s26_resume", {15'b0, bus.gntdata}, 16'h1);
    idleAll();
    tick(); tick();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      setReq(0, ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom), 16'($urandom));
      setReq(1, ($urandom_range(0, 2) != 0), 1'($urandom), 16'($urandom), 16'($urandom));
      setReq(2, ($urandom_range(0, 1) != 0), 1'($urandom), 16'($urandom), 16'($urandom));
      tick();
    end
    idleAll();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
